// File: rtl/pio_button_ctrl_if.sv
// Avalon-MM slave bus bundle for pio_button_ctrl.
//   address    : word address (2 bits)
//   chipselect : slave select
//   write_n    : write strobe, active low
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits)
interface pio_button_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_button_ctrl.sv
// Push-button PIO controller: polarity normalise, 2-FF synchronise, debounce,
// press-event capture (W1C) and maskable level interrupt, on an Avalon-MM slave.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port      : raw asynchronous button pins
//   irq          : level interrupt, |(edgecap & irqmask), combinational from registers
// Configuration macro PIO_BTN_DEBOUNCE_EN: when defined, per-bit debounce FSMs
// with DEBOUNCE_CYCLES-long acceptance windows; when undefined, DATA follows the
// synchroniser directly and no counter logic exists.
module pio_button_ctrl #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_button_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] pressed_c;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] db;       // debounced state, 1 = pressed
    logic [WIDTH-1:0] db_nxt;   // value db takes at the next edge
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] clr_c;
    logic             wr_c;
    logic [DATA_W-1:0] rd_c;
    logic             unused_wdata_c;

    assign pressed_c = ACTIVE_LOW ? ~in_port : in_port;

    // Two-flop synchroniser; resets to released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pressed_c;
            sync2 <= sync1;
        end
    end

`ifdef PIO_BTN_DEBOUNCE_EN
    typedef enum logic {ST_STABLE = 1'b0, ST_COUNTING = 1'b1} db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t        state_q [WIDTH];
    db_state_t        state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    // Debounce state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            db      <= db_nxt;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_nxt  = db;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2[i] != db[i]) begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                ST_COUNTING: begin
                    if (sync2[i] == db[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        db_nxt[i]  = sync2[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end
`else
    logic [DATA_W-1:0] unused_cfg_c;

    // db is the synchroniser output; its next value is the first stage
    assign db           = sync2;
    assign db_nxt       = sync1;
    assign unused_cfg_c = DATA_W'(DEBOUNCE_CYCLES) ^ DATA_W'(CNT_W);
`endif

    assign wr_c           = bus.chipselect & ~bus.write_n;
    assign clr_c          = (wr_c && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign rise_c         = db_nxt & ~db;
    assign unused_wdata_c = ^bus.writedata;

    // Read mux, zero-extended
    always_comb begin
        rd_c = '0;
        case (bus.address)
            ADDR_DATA:    rd_c = DATA_W'(db);
            ADDR_RAW:     rd_c = DATA_W'(sync2);
            ADDR_IRQMASK: rd_c = DATA_W'(irqmask_q);
            ADDR_EDGECAP: rd_c = DATA_W'(edgecap_q);
            default:      rd_c = '0;
        endcase
    end

    // Register file; a press set beats a same-cycle W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_q    <= '0;
            irqmask_q    <= '0;
            bus.readdata <= '0;
        end else begin
            edgecap_q    <= (edgecap_q & ~clr_c) | rise_c;
            bus.readdata <= rd_c;
            if (wr_c && bus.address == ADDR_IRQMASK) begin
                irqmask_q <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_button_ctrl.sv
// Self-checking bench for pio_button_ctrl (WIDTH=2, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1).
// A behavioural model tracks the expected register contents; scenario tasks also
// check the directed timing values.
module tb_pio_button_ctrl;
    localparam int unsigned W = 2;
    localparam int unsigned D = 8;
`ifdef PIO_BTN_DEBOUNCE_EN
    localparam bit          DEB = 1'b1;
    localparam int unsigned LAT = D + 2;   // in_port change -> DATA register, in clocks
`else
    localparam bit          DEB = 1'b0;
    localparam int unsigned LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    int checks = 0;
    int errors = 0;

    pio_button_ctrl_if bus ();

    pio_button_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: sync pipeline, run-length acceptance, register file
    logic [W-1:0] m_s1, m_s2, m_db, m_edge, m_mask, m_new, m_clr;
    logic [31:0]  m_rd;
    int           m_run [W];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_edge = '0; m_mask = '0; m_rd = '0;
            for (int i = 0; i < int'(W); i++) m_run[i] = 0;
        end else begin
            case (bus.address)
                2'd0: m_rd = {30'd0, m_db};
                2'd1: m_rd = {30'd0, m_s2};
                2'd2: m_rd = {30'd0, m_mask};
                default: m_rd = {30'd0, m_edge};
            endcase
            m_new = m_db;
            if (DEB) begin
                for (int i = 0; i < int'(W); i++) begin
                    if (m_s2[i] != m_db[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == int'(D)) begin
                            m_new[i] = m_s2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end else begin
                m_new = m_s1;
            end
            m_clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
            m_edge = (m_edge & ~m_clr) | (m_new & ~m_db);
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
            m_db = m_new;
            m_s2 = m_s1;
            m_s1 = ~in_port;
        end
    end

    function automatic logic m_irq();
        return |(m_edge & m_mask);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one write cycle, starting and ending on a falling edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = $urandom;
    endtask

    task automatic test_reset();
        in_port = 2'b00;
        bus_write(2'd2, 32'h3);
        tick(LAT + 3);
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || bus.readdata !== 32'd0) begin
            errors++; $display("FAIL reset_async: irq=%b rd=%0h expected 0/0", irq, bus.readdata);
        end
        in_port = 2'b11;
        tick(3);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            @(negedge clk);
            checks++;
            if (bus.readdata !== 32'd0 || bus.readdata !== m_rd || irq !== 1'b0) begin
                errors++; $display("FAIL reset_read a=%0d: rd=%0h irq=%b expected 0/0", a, bus.readdata, irq);
            end
        end
    endtask

    task automatic test_bounce();
        bus.address = 2'd0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 10; k++) begin
                in_port[0] = (k < 5) ? 1'b0 : 1'b1;
                @(negedge clk);
                checks++;
                if (bus.readdata !== m_rd || irq !== m_irq()) begin
                    errors++; $display("FAIL bounce_cycle p=%0d k=%0d: rd=%0h irq=%b expected %0h/%b", p, k, bus.readdata, irq, m_rd, m_irq());
                end
            end
        end
        tick(3);
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL bounce_data: got %0h expected 0", bus.readdata);
        end
        bus.address = 2'd3;
        tick(1);
        checks++;
        if (bus.readdata !== (DEB ? 32'd0 : 32'd1) || irq !== 1'b0) begin
            errors++; $display("FAIL bounce_edgecap: got %0h irq=%b expected %0h/0", bus.readdata, irq, DEB ? 0 : 1);
        end
        bus_write(2'd3, 32'h3);
    endtask

    task automatic test_clean_press();
        logic [31:0] exp;
        bus.address = 2'd0;
        in_port = 2'b10;
        for (int k = 1; k <= int'(LAT) + 3; k++) begin
            @(negedge clk);
            // DATA register changes on clock LAT; readdata shows it one clock later
            exp = (k >= int'(LAT) + 1) ? 32'd1 : 32'd0;
            checks++;
            if (bus.readdata !== exp || bus.readdata !== m_rd) begin
                errors++; $display("FAIL press_latency k=%0d: got %0h expected %0h", k, bus.readdata, exp);
            end
        end
        bus.address = 2'd3;
        tick(1);
        checks++;
        if (bus.readdata !== 32'd1 || irq !== 1'b0) begin
            errors++; $display("FAIL press_edgecap: got %0h irq=%b expected 1/0", bus.readdata, irq);
        end
        bus_write(2'd2, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL mask_irq: irq=%b expected 1", irq);
        end
    endtask

    task automatic test_w1c();
        bus_write(2'd3, 32'h2);
        tick(1);
        checks++;
        if (bus.readdata !== 32'd1 || irq !== 1'b1) begin
            errors++; $display("FAIL w1c_other_bit: got %0h irq=%b expected 1/1", bus.readdata, irq);
        end
        in_port = 2'b11;
        tick(LAT + 2);
        checks++;
        if (bus.readdata !== 32'd1) begin
            errors++; $display("FAIL w1c_release: got %0h expected 1", bus.readdata);
        end
        in_port = 2'b10;
        tick(LAT - 1);
        bus_write(2'd3, 32'h1);   // lands on the acceptance clock
        checks++;
        if (irq !== 1'b1 || m_edge !== 2'b01) begin
            errors++; $display("FAIL w1c_set_wins_irq: irq=%b expected 1", irq);
        end
        tick(1);
        checks++;
        if (bus.readdata !== 32'd1) begin
            errors++; $display("FAIL w1c_set_wins: got %0h expected 1", bus.readdata);
        end
        bus_write(2'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL w1c_clear_irq: irq=%b expected 0", irq);
        end
        tick(1);
        checks++;
        if (bus.readdata !== 32'd0 || bus.readdata !== m_rd) begin
            errors++; $display("FAIL w1c_clear: got %0h expected 0", bus.readdata);
        end
    endtask

    task automatic test_release_reset();
        logic [31:0] exp;
        in_port = 2'b11;
        tick(LAT + 2);
        checks++;
        if (bus.readdata !== 32'd0 || m_db !== 2'b00) begin
            errors++; $display("FAIL release_edgecap: got %0h expected 0", bus.readdata);
        end
        in_port = 2'b01;
        tick(2 + 5);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        bus.address = 2'd0;
        for (int k = 1; k <= int'(LAT) + 3; k++) begin
            @(negedge clk);
            exp = (k >= int'(LAT) + 1) ? 32'd2 : 32'd0;
            checks++;
            if (bus.readdata !== exp || bus.readdata !== m_rd) begin
                errors++; $display("FAIL reset_recount k=%0d: got %0h expected %0h", k, bus.readdata, exp);
            end
        end
        bus.address = 2'd3;
        tick(1);
        checks++;
        if (bus.readdata !== 32'd2 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_edgecap: got %0h irq=%b expected 2/0", bus.readdata, irq);
        end
        in_port = 2'b11;
        bus_write(2'd3, 32'h3);
        tick(LAT + 2);
    endtask

`ifndef PIO_BTN_DEBOUNCE_EN
    task automatic test_no_debounce();
        logic [31:0] exp;
        bus.address = 2'd0;
        for (int k = 1; k <= 10; k++) begin
            in_port[0] = (k <= 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            // Pin low during clocks 1..5 -> DATA readable on clocks 3..7
            exp = (k >= 3 && k <= 7) ? 32'd1 : 32'd0;
            checks++;
            if (bus.readdata !== exp || bus.readdata !== m_rd) begin
                errors++; $display("FAIL nodeb_follow k=%0d: got %0h expected %0h", k, bus.readdata, exp);
            end
        end
        bus.address = 2'd3;
        tick(1);
        checks++;
        if (bus.readdata[0] !== 1'b1) begin
            errors++; $display("FAIL nodeb_edgecap: got %0h expected bit0 set", bus.readdata);
        end
        bus_write(2'd3, 32'h3);
    endtask
`endif

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (bus.readdata !== m_rd || irq !== m_irq()) begin
                errors++; $display("FAIL random c=%0d: rd=%0h irq=%b expected %0h/%b", c, bus.readdata, irq, m_rd, m_irq());
            end
            if (hold == 0) begin
                in_port = 2'($urandom);
                hold = $urandom_range(1, 2 * D + 2);
            end else begin
                hold--;
            end
            bus.address    = 2'($urandom);
            bus.chipselect = ($urandom_range(0, 3) == 0);
            bus.write_n    = ($urandom_range(0, 1) == 0);
            bus.writedata  = $urandom;
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = 2'b11;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        test_reset();
        test_bounce();
        test_clean_press();
        test_w1c();
        test_release_reset();
`ifndef PIO_BTN_DEBOUNCE_EN
        test_no_debounce();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
